y_linebuf_ctrl: RTL and testbench

Write/read sequencer for a two-bank (ping-pong) luma line buffer. It is fed by the 2-cycle RGB-to-luma stage (8-bit luma, dv, vs) and commits each active line into an external dual-port RAM bank. It hands completed lines to a downstream consumer through a valid/ack handshake. It tracks column and line position, and drops lines it cannot store, flagging them as overflow.

---
 rtl/y_linebuf_ctrl.sv | 159 +++++++++++++++
 tb/tb_y_linebuf_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/y_linebuf_ctrl.sv
// Ping-pong luma line buffer sequencer: writes each active line into one
// of two RAM banks and presents completed lines to a consumer through a
// valid/ack handshake. Lines that find no free bank are dropped and flagged.
module y_linebuf_ctrl #(
  parameter int LINE_W = 640,
  parameter int ADDR_W = 10,
  parameter int LCNT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        y_i,
  input  logic              dv_i,
  input  logic              vs_i,
  output logic              wr_en_o,
  output logic              wr_bank_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              line_valid_o,
  output logic              rd_bank_o,
  output logic [ADDR_W:0]   line_len_o,
  output logic [LCNT_W-1:0] line_idx_o,
  input  logic              line_ack_i,
  output logic              frame_start_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {IDLE, GAP, WRITE, DROP} state_t;

  localparam logic [ADDR_W:0] COL_MAX = (ADDR_W+1)'(LINE_W);

  state_t              state, state_nxt;
  logic                dv_q, vs_q;
  logic [1:0]          full;
  logic                wr_bank, rd_bank;
  logic [ADDR_W:0]     col;
  logic [LCNT_W-1:0]   line_cnt;
  logic [ADDR_W:0]     len_mem [2];
  logic [LCNT_W-1:0]   idx_mem [2];

  logic                wr_en_p1, wr_bank_p1, frame_start_p1, overflow_p1;
  logic [ADDR_W-1:0]   wr_addr_p1;
  logic [7:0]          wr_data_p1;

  logic vs_rise, dv_rise, dv_fall, wr_full;
  logic pix_take, pix_write, pix_trunc;
  logic commit, drop_start, drop_end, ack_do;

  // Edge detection and per-cycle event decode; a new frame overrides everything.
  always_comb begin
    vs_rise    = vs_i & ~vs_q;
    dv_rise    = dv_i & ~dv_q;
    dv_fall    = ~dv_i & dv_q;
    wr_full    = full[wr_bank];
    pix_take   = ~vs_rise & (((state == GAP) & dv_rise & ~wr_full) |
                             ((state == WRITE) & dv_i));
    pix_write  = pix_take & (col < COL_MAX);
    pix_trunc  = pix_take & ~(col < COL_MAX);
    commit     = ~vs_rise & (state == WRITE) & dv_fall & (col != '0);
    drop_start = ~vs_rise & (state == GAP) & dv_rise & wr_full;
    drop_end   = ~vs_rise & (state == DROP) & dv_fall;
    ack_do     = line_ack_i & full[rd_bank];
  end

  // Next-state logic for the line sequencer.
  always_comb begin
    state_nxt = state;
    if (vs_rise) begin
      state_nxt = GAP;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        GAP:     if (dv_rise) state_nxt = wr_full ? DROP : WRITE;
        WRITE:   if (dv_fall) state_nxt = GAP;
        DROP:    if (dv_fall) state_nxt = GAP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bank bookkeeping: full flags, bank pointers, column and line counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q     <= 1'b0;
      vs_q     <= 1'b0;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      col      <= '0;
      line_cnt <= '0;
      for (int b = 0; b < 2; b++) begin
        len_mem[b] <= '0;
        idx_mem[b] <= '0;
      end
    end else begin
      dv_q <= dv_i;
      vs_q <= vs_i;
      if (vs_rise) begin
        full     <= '0;
        wr_bank  <= 1'b0;
        rd_bank  <= 1'b0;
        col      <= '0;
        line_cnt <= '0;
      end else begin
        if (ack_do) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
        if (pix_write) col <= col + (ADDR_W+1)'(1);
        if (commit) begin
          full[wr_bank]    <= 1'b1;
          len_mem[wr_bank] <= col;
          idx_mem[wr_bank] <= line_cnt;
          wr_bank          <= ~wr_bank;
          col              <= '0;
        end
        if (commit || drop_end) line_cnt <= line_cnt + LCNT_W'(1);
      end
    end
  end

  // Stage p1: registered RAM write port, frame pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_p1       <= 1'b0;
      wr_bank_p1     <= 1'b0;
      wr_addr_p1     <= '0;
      wr_data_p1     <= '0;
      frame_start_p1 <= 1'b0;
      overflow_p1    <= 1'b0;
    end else begin
      wr_en_p1       <= pix_write;
      frame_start_p1 <= vs_rise;
      if (pix_write) begin
        wr_bank_p1 <= wr_bank;
        wr_addr_p1 <= col[ADDR_W-1:0];
        wr_data_p1 <= y_i;
      end
      if (drop_start || pix_trunc) overflow_p1 <= 1'b1;
    end
  end

  assign wr_en_o       = wr_en_p1;
  assign wr_bank_o     = wr_bank_p1;
  assign wr_addr_o     = wr_addr_p1;
  assign wr_data_o     = wr_data_p1;
  assign frame_start_o = frame_start_p1;
  assign overflow_o    = overflow_p1;
  assign line_valid_o  = full[rd_bank];
  assign rd_bank_o     = rd_bank;
  assign line_len_o    = len_mem[rd_bank];
  assign line_idx_o    = idx_mem[rd_bank];

endmodule

// File: tb/tb_y_linebuf_ctrl.sv
// Directed bench for y_linebuf_ctrl with a short line width (8 pixels).
module tb_y_linebuf_ctrl;

  localparam int LW  = 8;
  localparam int AW  = 10;
  localparam int LCW = 10;

  logic           clk, rst;
  logic [7:0]     y;
  logic           dv, vs, ack;
  logic           wr_en, wr_bank;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_data;
  logic           line_valid, rd_bank;
  logic [AW:0]    line_len;
  logic [LCW-1:0] line_idx;
  logic           frame_start, overflow;

  int total  = 0;
  int passed = 0;

  y_linebuf_ctrl #(.LINE_W(LW), .ADDR_W(AW), .LCNT_W(LCW)) dut (
    .clk(clk), .rst(rst), .y_i(y), .dv_i(dv), .vs_i(vs),
    .wr_en_o(wr_en), .wr_bank_o(wr_bank), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .line_valid_o(line_valid), .rd_bank_o(rd_bank), .line_len_o(line_len),
    .line_idx_o(line_idx), .line_ack_i(ack), .frame_start_o(frame_start),
    .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dv = 1'b0; vs = 1'b0; ack = 1'b0; y = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wr_en"},       32'(wr_en), 0);
    chk({tag, ".wr_bank"},     32'(wr_bank), 0);
    chk({tag, ".wr_addr"},     32'(wr_addr), 0);
    chk({tag, ".wr_data"},     32'(wr_data), 0);
    chk({tag, ".line_valid"},  32'(line_valid), 0);
    chk({tag, ".rd_bank"},     32'(rd_bank), 0);
    chk({tag, ".line_len"},    32'(line_len), 0);
    chk({tag, ".line_idx"},    32'(line_idx), 0);
    chk({tag, ".frame_start"}, 32'(frame_start), 0);
    chk({tag, ".overflow"},    32'(overflow), 0);
  endtask

  task automatic frame();
    vs = 1'b1;
    tick();
    chk("frame_start.pulse", 32'(frame_start), 1);
    tick();
    chk("frame_start.once", 32'(frame_start), 0);
    vs = 1'b0;
  endtask

  // Drive n pixels base..base+n-1, then drop dv; checks each registered write.
  task automatic send_line(input int n, input int base, input bit wr, input int bank);
    for (int i = 0; i < n; i++) begin
      dv = 1'b1;
      y  = 8'(base + i);
      tick();
      chk("line.wr_en", 32'(wr_en), (wr && i < LW) ? 1 : 0);
      if (wr && i < LW) begin
        chk("line.wr_addr", 32'(wr_addr), 32'(i));
        chk("line.wr_data", 32'(wr_data), 32'((base + i) % 256));
        chk("line.wr_bank", 32'(wr_bank), 32'(bank));
      end
    end
    dv = 1'b0;
    tick();
    chk("line.end_wr_en", 32'(wr_en), 0);
  endtask

  task automatic chk_rd(input string tag, input int v, input int b, input int len, input int idx);
    chk({tag, ".valid"}, 32'(line_valid), 32'(v));
    chk({tag, ".rd_bank"}, 32'(rd_bank), 32'(b));
    if (v != 0) begin
      chk({tag, ".len"}, 32'(line_len), 32'(len));
      chk({tag, ".idx"}, 32'(line_idx), 32'(idx));
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    // Reset state and a single 5-pixel line.
    do_reset();
    chk_zero("reset");
    frame();
    send_line(5, 10, 1'b1, 0);
    chk_rd("one_line", 1, 0, 5, 0);
    chk("one_line.overflow", 32'(overflow), 0);
    chk("one_line.frame_start", 32'(frame_start), 0);

    // Two stored lines, a third dropped, then two acks and a spurious ack.
    do_reset();
    frame();
    send_line(4, 20, 1'b1, 0);
    send_line(6, 30, 1'b1, 1);
    chk_rd("two_lines", 1, 0, 4, 0);
    chk("two_lines.overflow", 32'(overflow), 0);
    send_line(3, 50, 1'b0, 0);
    chk("drop.overflow", 32'(overflow), 1);
    chk_rd("drop.keep", 1, 0, 4, 0);
    do_ack();
    chk_rd("ack1", 1, 1, 6, 1);
    do_ack();
    chk_rd("ack2", 0, 0, 0, 0);
    do_ack();
    chk_rd("ack_ignored", 0, 0, 0, 0);
    send_line(2, 60, 1'b1, 0);
    chk_rd("after_drop", 1, 0, 2, 3);

    // Over-long line truncated at LINE_W.
    do_reset();
    frame();
    send_line(11, 200, 1'b1, 0);
    chk_rd("trunc", 1, 0, 8, 0);
    chk("trunc.overflow", 32'(overflow), 1);

    // Frame sync arriving mid-line with bank 0 full.
    do_reset();
    frame();
    send_line(4, 70, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      dv = 1'b1;
      y  = 8'(75 + i);
      tick();
      chk("partial.wr_en", 32'(wr_en), 1);
      chk("partial.wr_addr", 32'(wr_addr), 32'(i));
      chk("partial.wr_bank", 32'(wr_bank), 1);
    end
    vs = 1'b1;
    tick();
    chk("vs_mid.wr_en", 32'(wr_en), 0);
    chk("vs_mid.frame_start", 32'(frame_start), 1);
    chk_rd("vs_mid", 0, 0, 0, 0);
    vs = 1'b0;
    dv = 1'b0;
    tick();
    send_line(3, 80, 1'b1, 0);
    chk_rd("vs_mid.next", 1, 0, 3, 0);

    // Ack of bank 0 coinciding with a line start targeting bank 0.
    do_reset();
    frame();
    send_line(4, 90, 1'b1, 0);
    send_line(5, 100, 1'b1, 1);
    chk_rd("race.before", 1, 0, 4, 0);
    ack = 1'b1;
    dv  = 1'b1;
    y   = 8'd110;
    tick();
    ack = 1'b0;
    chk("race.wr_en", 32'(wr_en), 0);
    chk("race.overflow", 32'(overflow), 1);
    chk_rd("race.after_ack", 1, 1, 5, 1);
    for (int i = 0; i < 2; i++) begin
      y = 8'(111 + i);
      tick();
      chk("race.drop_wr_en", 32'(wr_en), 0);
    end
    dv = 1'b0;
    tick();
    send_line(2, 120, 1'b1, 0);
    chk_rd("race.next_hold", 1, 1, 5, 1);
    do_ack();
    chk_rd("race.next", 1, 0, 2, 3);

    // Reset asserted in the middle of a line.
    do_reset();
    frame();
    dv = 1'b1;
    y  = 8'd1;
    tick();
    y = 8'd2;
    tick();
    chk("mid_rst.wr_en", 32'(wr_en), 1);
    chk("mid_rst.wr_addr", 32'(wr_addr), 1);
    rst = 1'b1;
    tick();
    chk_zero("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_rst.idle_wr_en", 32'(wr_en), 0);
    end
    dv = 1'b0;
    tick();
    send_line(3, 5, 1'b0, 0);
    chk("mid_rst.overflow", 32'(overflow), 0);
    chk_rd("mid_rst.no_line", 0, 0, 0, 0);
    frame();
    send_line(2, 7, 1'b1, 0);
    chk_rd("mid_rst.recover", 1, 0, 2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
